write_arbiter: RTL and testbench

//  Write-side counterpart of the memory-pool read path: arbitrates write requests from load (DDR

---
 rtl/write_arbiter_pkg.sv | 39 +++
 rtl/write_arbiter_if.sv | 15 +
 rtl/write_arbiter_grant.sv | 44 ++++
 rtl/write_arbiter.sv | 86 ++++++++
 tb/tb_write_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/write_arbiter_pkg.sv
// Shared definitions for the image-memory-pool write arbiter: owner encodings,
// default lane geometry and the rotating-priority pick used by the grant FSM.
package write_arbiter_pkg;

  typedef enum logic [2:0] {
    NONE_USE = 3'b000,
    LOAD_USE = 3'b001,
    CONV_USE = 3'b010,
    MISC_USE = 3'b100
  } owner_e;

  localparam int CHL_PARA_DEF        = 8;
  localparam int BANK_UNIT_WIDTH_DEF = 8;
  localparam int LANE_W              = CHL_PARA_DEF * BANK_UNIT_WIDTH_DEF;

  // First requester after the current owner in load->conv->misc order.
  // NONE (and MISC) start the scan at load, which gives the fixed-priority idle case.
  function automatic owner_e rr_pick(input owner_e owner, input logic [2:0] req);
    rr_pick = NONE_USE;
    case (owner)
      LOAD_USE: begin
        if (req[1])      rr_pick = CONV_USE;
        else if (req[2]) rr_pick = MISC_USE;
        else if (req[0]) rr_pick = LOAD_USE;
      end
      CONV_USE: begin
        if (req[2])      rr_pick = MISC_USE;
        else if (req[0]) rr_pick = LOAD_USE;
        else if (req[1]) rr_pick = CONV_USE;
      end
      default: begin
        if (req[0])      rr_pick = LOAD_USE;
        else if (req[1]) rr_pick = CONV_USE;
        else if (req[2]) rr_pick = MISC_USE;
      end
    endcase
  endfunction

endpackage

// File: rtl/write_arbiter_if.sv
// One client's write request channel into the bank group (valid/ready handshake).
interface write_arbiter_if #(
  parameter int ROW_PARA   = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 256
);
  logic                  write_valid;
  logic [ROW_PARA-1:0]   write_bank_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_ready;

  modport master (output write_valid, write_bank_en, write_addr, write_data, input write_ready);
  modport slave  (input  write_valid, write_bank_en, write_addr, write_data, output write_ready);
endinterface

// File: rtl/write_arbiter_grant.sv
// Owner/burst tracking and one-hot grant generation; the current owner keeps the
// port until MAX_BURST beats are used while someone else waits.
module write_grant_fsm
  import write_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] valid_i,
  output logic [2:0] ready_o,
  output logic [2:0] owner_o
);
  localparam int CW = $clog2(MAX_BURST + 1);

  owner_e        owner_q, grant;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          keep;

  always_comb begin
    keep  = (|(valid_i & owner_q)) &&
            ((cnt_q < CW'(MAX_BURST)) || !(|(valid_i & ~owner_q)));
    grant = keep ? owner_q : rr_pick(owner_q, valid_i);
    cnt_d = '0;
    if (grant != NONE_USE) begin
      // A fresh owner, or the same owner after an expired burst, opens a new burst.
      if (grant != owner_q || cnt_q == CW'(MAX_BURST)) cnt_d = CW'(1);
      else                                             cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= NONE_USE;
      cnt_q   <= '0;
    end else begin
      owner_q <= grant;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = rst_n ? 3'(grant) : 3'b000;
  assign owner_o = 3'(owner_q);
endmodule

// File: rtl/write_arbiter.sv
// Write arbiter for one bank group: grants load/conv/misc, selects the winning beat,
// masks disabled lanes and registers it onto the bank-group write port (latency 1).
module write_arbiter
  import write_arbiter_pkg::*;
#(
  parameter int ROW_PARA        = 4,
  parameter int CHL_PARA        = CHL_PARA_DEF,
  parameter int BANK_UNIT_WIDTH = BANK_UNIT_WIDTH_DEF,
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_BURST       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  write_arbiter_if.slave        load_if,
  write_arbiter_if.slave        conv_if,
  write_arbiter_if.slave        misc_if,
  output logic                  ram_write_en_o,
  output logic [ROW_PARA-1:0]   ram_write_bank_en_o,
  output logic [ADDR_WIDTH-1:0] ram_write_addr_o,
  output logic [DATA_WIDTH-1:0] ram_write_data_o,
  output logic [2:0]            write_owner_o
);
  localparam int LW = CHL_PARA * BANK_UNIT_WIDTH;

  logic [2:0]            ready;
  logic                  beat;
  logic [ROW_PARA-1:0]   sel_ben;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data, mask_data;

  logic                  en_q;
  logic [ROW_PARA-1:0]   ben_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  write_grant_fsm #(.MAX_BURST(MAX_BURST)) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i ({misc_if.write_valid, conv_if.write_valid, load_if.write_valid}),
    .ready_o (ready),
    .owner_o (write_owner_o)
  );

  assign load_if.write_ready = ready[0];
  assign conv_if.write_ready = ready[1];
  assign misc_if.write_ready = ready[2];
  assign beat = |ready;

  // Grant is one-hot or zero, so an AND-OR select is sufficient.
  assign sel_ben  = ({ROW_PARA{ready[0]}}   & load_if.write_bank_en) |
                    ({ROW_PARA{ready[1]}}   & conv_if.write_bank_en) |
                    ({ROW_PARA{ready[2]}}   & misc_if.write_bank_en);
  assign sel_addr = ({ADDR_WIDTH{ready[0]}} & load_if.write_addr) |
                    ({ADDR_WIDTH{ready[1]}} & conv_if.write_addr) |
                    ({ADDR_WIDTH{ready[2]}} & misc_if.write_addr);
  assign sel_data = ({DATA_WIDTH{ready[0]}} & load_if.write_data) |
                    ({DATA_WIDTH{ready[1]}} & conv_if.write_data) |
                    ({DATA_WIDTH{ready[2]}} & misc_if.write_data);

  for (genvar g = 0; g < ROW_PARA; g++) begin : g_lane
    assign mask_data[g*LW +: LW] = sel_ben[g] ? sel_data[g*LW +: LW] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      ben_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (beat) begin
      en_q   <= |sel_ben;
      ben_q  <= sel_ben;
      addr_q <= sel_addr;
      data_q <= mask_data;
    end else begin
      en_q   <= 1'b0;
      ben_q  <= '0;
    end
  end

  assign ram_write_en_o      = en_q;
  assign ram_write_bank_en_o = ben_q;
  assign ram_write_addr_o    = addr_q;
  assign ram_write_data_o    = data_q;
endmodule

// File: tb/tb_write_arbiter.sv
// Bench for write_arbiter: idle-grant vector table, hand sequences for reset,
// priority, burst fairness and lone owner, then random traffic against a reference model.
module tb_write_arbiter;
  localparam int AW = 48, DW = 256, LW = 64, MAXB = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  write_arbiter_if lif(), cif(), mif();

  logic            ram_en;
  logic [3:0]      ram_ben;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic [2:0]      owner, rdy;

  write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .load_if(lif), .conv_if(cif), .misc_if(mif),
    .ram_write_en_o(ram_en), .ram_write_bank_en_o(ram_ben),
    .ram_write_addr_o(ram_addr), .ram_write_data_o(ram_data),
    .write_owner_o(owner)
  );

  logic [2:0]    v;
  logic [3:0]    ben  [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] data [3];

  assign lif.write_valid = v[0]; assign lif.write_bank_en = ben[0];
  assign lif.write_addr  = addr[0]; assign lif.write_data = data[0];
  assign cif.write_valid = v[1]; assign cif.write_bank_en = ben[1];
  assign cif.write_addr  = addr[1]; assign cif.write_data = data[1];
  assign mif.write_valid = v[2]; assign mif.write_bank_en = ben[2];
  assign mif.write_addr  = addr[2]; assign mif.write_data = data[2];
  assign rdy = {mif.write_ready, cif.write_ready, lif.write_ready};

  int checks = 0, errors = 0;

  // Reference model: owner index (-1 none), beats in current burst, expected port registers.
  int            m_owner, m_cnt;
  logic          m_en;
  logic [3:0]    m_ben;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [2:0]    last_rdy;
  int            last_g;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mask(logic [DW-1:0] d, logic [3:0] b);
    logic [DW-1:0] r = '0;
    for (int l = 0; l < 4; l++) if (b[l]) r[l*LW +: LW] = d[l*LW +: LW];
    return r;
  endfunction

  function automatic int model_grant();
    bit others = 0;
    for (int i = 0; i < 3; i++) if (i != m_owner && v[i]) others = 1;
    if (m_owner >= 0 && v[m_owner] && (m_cnt < MAXB || !others)) return m_owner;
    for (int k = 1; k <= 3; k++) if (v[(m_owner + k) % 3]) return (m_owner + k) % 3;
    return -1;
  endfunction

  // Called at a negedge with inputs applied; checks, advances the model across the posedge.
  task automatic tick();
    int g;
    #1;
    g = model_grant();
    chk("ready", DW'(rdy), (g < 0) ? '0 : DW'(1) << g);
    chk("ram_en", DW'(ram_en), DW'(m_en));
    chk("ram_bank_en", DW'(ram_ben), DW'(m_ben));
    chk("ram_addr", DW'(ram_addr), DW'(m_addr));
    chk("ram_data", ram_data, m_data);
    chk("owner", DW'(owner), (m_owner < 0) ? '0 : DW'(1) << m_owner);
    last_rdy = rdy;
    last_g   = g;
    if (g < 0) begin
      m_cnt = 0; m_en = 1'b0; m_ben = '0;
    end else begin
      m_cnt  = (g != m_owner || m_cnt == MAXB) ? 1 : m_cnt + 1;
      m_en   = |ben[g];
      m_ben  = ben[g];
      m_addr = addr[g];
      m_data = mask(data[g], ben[g]);
    end
    m_owner = g;
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the async clear, releases at a later negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", DW'(rdy), '0);
    chk("rst_en", DW'(ram_en), '0);
    chk("rst_bank_en", DW'(ram_ben), '0);
    chk("rst_addr", DW'(ram_addr), '0);
    chk("rst_data", ram_data, '0);
    chk("rst_owner", DW'(owner), '0);
    m_owner = -1; m_cnt = 0; m_en = 1'b0; m_ben = '0; m_addr = '0; m_data = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic new_txn(int i);
    ben[i]  = 4'($urandom);
    addr[i] = {16'($urandom), 32'($urandom)};
    for (int w = 0; w < 8; w++) data[i][w*32 +: 32] = $urandom;
  endtask

  typedef struct {
    logic [2:0] v;
    logic [3:0] ben;
    logic [2:0] rdy;
    logic       en;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int nconv, cnt;
    int runs[$];
    logic [2:0] rv[$];

    tbl[0] = '{3'b000, 4'hF, 3'b000, 1'b0};
    tbl[1] = '{3'b001, 4'hF, 3'b001, 1'b1};
    tbl[2] = '{3'b110, 4'hF, 3'b010, 1'b1};
    tbl[3] = '{3'b100, 4'h5, 3'b100, 1'b1};
    tbl[4] = '{3'b111, 4'h0, 3'b001, 1'b0};
    tbl[5] = '{3'b101, 4'hA, 3'b001, 1'b1};
    tbl[6] = '{3'b010, 4'h3, 3'b010, 1'b1};

    v = '0;
    for (int i = 0; i < 3; i++) begin
      ben[i] = 4'hF; addr[i] = AW'(i + 1); data[i] = {DW{1'b1}};
    end
    m_owner = -1; m_cnt = 0; m_en = 1'b0; m_ben = '0; m_addr = '0; m_data = '0;
    last_rdy = '0; last_g = -1;
    repeat (2) @(negedge clk);

    // Reset with every client requesting; load wins on release.
    v = 3'b111;
    do_reset();
    tick();
    chk("rst_first_grant", DW'(last_rdy), DW'(3'b001));
    chk("rst_first_en", DW'(ram_en), DW'(1'b1));

    // Idle-state grant, lane masking and zero bank_en, all ones data.
    for (int t = 0; t < 7; t++) begin
      v = '0;
      do_reset();
      v = tbl[t].v;
      for (int i = 0; i < 3; i++) begin
        ben[i] = tbl[t].ben; data[i] = {DW{1'b1}}; addr[i] = AW'(16 * (t + 1) + i);
      end
      tick();
      chk("tbl_ready", DW'(last_rdy), DW'(tbl[t].rdy));
      chk("tbl_en", DW'(ram_en), DW'(tbl[t].en));
      chk("tbl_data", ram_data, (tbl[t].rdy != 0) ? mask({DW{1'b1}}, tbl[t].ben) : '0);
    end

    // conv beats misc from idle; misc only after conv's 16-beat burst.
    v = '0;
    do_reset();
    ben[1] = 4'hF; ben[2] = 4'hF; addr[1] = 48'h10; addr[2] = 48'h20;
    v = 3'b110;
    tick();
    chk("prio_addr", DW'(ram_addr), DW'(48'h10));
    nconv = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_rdy == 3'b100) break;
      if (last_rdy == 3'b010) nconv++;
    end
    chk("prio_conv_beats", DW'(nconv), DW'(16));
    v[1] = 1'b0;
    tick();
    chk("prio_misc_after_drop", DW'(last_rdy), DW'(3'b100));

    // load and conv both saturating: alternating 16-beat bursts, no idle cycle.
    v = '0;
    do_reset();
    ben[0] = 4'h9; ben[1] = 4'h6;
    v = 3'b011;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (rv.size() == 0 || rv[$] != last_rdy) begin
        rv.push_back(last_rdy); runs.push_back(1);
      end else runs[runs.size() - 1]++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("fair_len", DW'(runs.size() > k ? runs[k] : 0), DW'(16));
      chk("fair_who", DW'(rv.size() > k ? rv[k] : 3'b000), (k % 2) ? DW'(3'b010) : DW'(3'b001));
    end

    // misc alone for 40 beats across a burst expiry.
    v = '0;
    do_reset();
    ben[2] = 4'hC;
    v = 3'b100;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      addr[2] = AW'(k);
      for (int w = 0; w < 8; w++) data[2][w*32 +: 32] = 32'(k * 8 + w);
      tick();
      if (last_rdy == 3'b100) cnt++;
    end
    chk("lone_grants", DW'(cnt), DW'(40));
    chk("lone_last_addr", DW'(ram_addr), DW'(39));
    v = '0;
    tick();

    // Reset in the middle of a conv burst, then fixed priority again.
    ben[1] = 4'hF; ben[0] = 4'hF;
    v = 3'b010;
    repeat (5) tick();
    do_reset();
    v = 3'b011;
    tick();
    chk("post_rst_grant", DW'(last_rdy), DW'(3'b001));

    // Random traffic with hold-until-ready clients and occasional resets.
    for (int i = 0; i < 3; i++) new_txn(i);
    v = '0;
    for (int c = 0; c < 1500; c++) begin
      int p;
      p = (c / 300) % 3 == 0 ? 25 : ((c / 300) % 3 == 1 ? 60 : 97);
      for (int i = 0; i < 3; i++) begin
        if (last_g == i) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 99) < p) begin
          new_txn(i); v[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        last_g = -1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
